// File: rtl/wb_regfile.sv
// Writeback stage: selects the final writeback value (ALU, CSR or aligned and
// extended load data), commits it to the 32-entry integer register file, and
// serves two decode read ports with same-cycle write-through bypass. A 64-bit
// counter tracks committed register writes for debug and perf.
module wb_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      W_op,
  input  logic [2:0]      W_f3,
  input  logic [4:0]      W_rd,
  input  logic            W_use_rd,
  input  logic [XLEN-1:0] W_aluout,
  input  logic [XLEN-1:0] W_csr,
  input  logic [XLEN-1:0] ld_data,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_we,
  output logic [63:0]     wb_count
);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  logic [XLEN-1:0] regs_q [NREG];
  logic [63:0]     wb_count_q;
  logic [63:0]     wb_count_d;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_val;

  // Pick the addressed byte and halfword out of the raw memory word.
  always_comb begin
    ld_byte = 8'h00;
    case (W_aluout[1:0])
      2'b00:   ld_byte = ld_data[7:0];
      2'b01:   ld_byte = ld_data[15:8];
      2'b10:   ld_byte = ld_data[23:16];
      2'b11:   ld_byte = ld_data[31:24];
      default: ld_byte = 8'h00;
    endcase
    // Bit 0 of the address is ignored for halfwords; misalignment is not trapped here.
    if (W_aluout[1]) begin
      ld_half = ld_data[31:16];
    end else begin
      ld_half = ld_data[15:0];
    end
  end

  // Extend the extracted load value according to funct3.
  always_comb begin
    ld_val = ld_data;
    case (W_f3)
      3'b000:  ld_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_val = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  ld_val = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  ld_val = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_val = ld_data;
    endcase
  end

  // Final writeback select and write enable; writes to x0 never count.
  always_comb begin
    if (W_op == OP_LOAD) begin
      wb_data = ld_val;
    end else if (W_op == OP_SYSTEM) begin
      wb_data = W_csr;
    end else begin
      wb_data = W_aluout;
    end
    wb_we = W_use_rd && (W_rd != 5'd0);
  end

  // Read port 1: x0 is zero, the in-flight write is bypassed, else the array.
  always_comb begin
    if (rs1_addr == 5'd0) begin
      rs1_data = '0;
    end else if (wb_we && (rs1_addr == W_rd)) begin
      rs1_data = wb_data;
    end else begin
      rs1_data = regs_q[rs1_addr];
    end
  end

  // Read port 2: same rules as port 1, evaluated independently.
  always_comb begin
    if (rs2_addr == 5'd0) begin
      rs2_data = '0;
    end else if (wb_we && (rs2_addr == W_rd)) begin
      rs2_data = wb_data;
    end else begin
      rs2_data = regs_q[rs2_addr];
    end
  end

  // Register array commit; reset clears every entry immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_we) begin
      regs_q[W_rd] <= wb_data;
    end
  end

  // Next value of the committed-write counter; wraps silently at 2^64.
  always_comb begin
    if (wb_we) begin
      wb_count_d = wb_count_q + 64'd1;
    end else begin
      wb_count_d = wb_count_q;
    end
  end

  // Committed-write counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_count_q <= 64'd0;
    end else begin
      wb_count_q <= wb_count_d;
    end
  end

  assign wb_count = wb_count_q;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback-stage consumer of the W pipeline register. It selects the final writeback value (ALU result, CSR read value, or load data aligned and extended by funct3) and commits it to the 32-entry integer register file. It serves the decode stage's two read ports with same-cycle write-through bypass. It also keeps a 64-bit retired-writeback counter for debug and perf.

Parameters:
XLEN, 32, data width of registers and datapaths.
NREG, 32, number of architectural registers; x0 hardwired to zero.

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
W_op  in  5  opcode bits [6:2] of the W-stage instruction.
W_f3  in  3  funct3 of the W-stage instruction.
W_rd  in  5  destination register index.
W_use_rd  in  1  instruction writes rd.
W_aluout  in  XLEN  ALU result or effective address.
W_csr  in  XLEN  CSR read value.
ld_data  in  XLEN  raw word returned by the data memory for the load in W.
rs1_addr  in  5  decode read port 1 index.
rs2_addr  in  5  decode read port 2 index.
rs1_data  out  XLEN  read port 1 data.
rs2_data  out  XLEN  read port 2 data.
wb_data  out  XLEN  selected writeback value, also sent to the forwarding mux.
wb_we  out  1  register write actually performed this cycle.
wb_count  out  64  number of committed register writes since reset.

Behaviour:
- Writeback select is combinational:
  - W_op == 5'b00000 (LOAD) -> load-extended value.
  - W_op == 5'b11100 (SYSTEM) -> W_csr.
  - Otherwise -> W_aluout.
- Load extraction uses offset = W_aluout[1:0]:
  - f3 000 LB: byte at offset, sign-extended.
  - f3 100 LBU: byte at offset, zero-extended.
  - f3 001 LH: halfword selected by W_aluout[1] (bit 0 ignored; misalignment not trapped here), sign-extended.
  - f3 101 LHU: same halfword selection, zero-extended.
  - f3 010 LW and all other f3 values: full ld_data.
- wb_we = W_use_rd && (W_rd != 0), combinational.
- Register write: on posedge clk, when wb_we is high, regs[W_rd] <= wb_data. Writes to x0 are always discarded.
- Reads are combinational:
  - Index 0 returns 0.
  - If wb_we is high and the read index equals W_rd, return wb_data (write-through bypass). This applies to both ports independently and simultaneously.
  - Otherwise return regs[index].
- wb_count increments by 1 on each posedge where wb_we is high. It wraps from 2^64-1 to 0 with no flag.
- Reset, asynchronous:
  - All regs and wb_count go to 0 immediately.
  - rs1_data and rs2_data therefore read 0, unless bypass is active from the current W inputs.
  - wb_data and wb_we follow their combinational inputs.
- Reset asserted mid-cycle while wb_we is high: the write is lost and the register stays 0. Reset deassertion takes effect at the next posedge.
- No stall input. The upstream W register determines validity; a bubble arrives as W_use_rd = 0.
- Latency:
  - Written value is visible on read ports in the same cycle via bypass, and from the array from the next cycle on.
  - wb_count reflects a write one cycle after the edge that performs it.

Test Plan:
- Reset then read x1..x31 -> all 0; wb_count == 0. Write x5 = 0x12345678 (op 01100, use_rd = 1) -> next cycle rs1_data(x5) = 0x12345678, wb_count = 1.
- Write rd = 0 with W_aluout = 0xFFFFFFFF, use_rd = 1 -> wb_we = 0; x0 reads 0; wb_count unchanged.
- Load, ld_data = 0x80FF7F01:
  - LB, offset 3 -> wb_data 0xFFFFFF80.
  - LBU, offset 3 -> 0x00000080.
  - LH, offset 2 -> 0xFFFF80FF.
  - LHU, offset 0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
  - f3 = 011 -> 0x80FF7F01.
- SYSTEM op with W_csr = 0xDEADBEEF, W_aluout = 0x1 -> x7 written with 0xDEADBEEF.
- Same-cycle bypass: x9 holds 0x11; write x9 = 0x22 with rs1_addr = rs2_addr = 9 -> both ports read 0x22 in that cycle; with use_rd = 0 both read 0x11.
- Assert rst asynchronously between edges after writing x3 -> rs1_data(x3) drops to 0 before the next edge; wb_count = 0; writes resume normally after deassertion.
